monta_estado_cubo: RTL and testbench

Downstream consumer of the colour-identification stage. It accepts one classified facelet colour (3-bit code) per handshake. Facelets arrive in row-major order (linha, coluna 0..2) for faces 0..5. The block stores all 54 codes in an internal state register file and checks per-colour counts. It presents the assembled cube state to the solver through a combinational read port.

---
 rtl/monta_estado_cubo_pkg.sv | 41 ++++
 rtl/monta_estado_cubo_banco_cores.sv | 50 +++++
 rtl/monta_estado_cubo.sv | 164 ++++++++++++++++
 tb/tb_monta_estado_cubo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/monta_estado_cubo_pkg.sv
// Shared definitions for the cube-state assembler.
// Holds geometry (faces, facelets, sticker count), colour codes, FSM state
// constants and the facelet index helper.
// Optional build macro CENTRO_DISTINTO_EN lengthens validation by one
// centre-uniqueness step per face.
package monta_estado_cubo_pkg;

  localparam int COR_W      = 3;
  localparam int N_FACES    = 6;
  localparam int N_FACELETS = 9;
  localparam int N_STICKERS = N_FACES * N_FACELETS;
  localparam int ADDR_W     = 6;
  localparam int CNT_W      = 4;

  localparam logic [COR_W-1:0] COR_BRANCO       = 3'd0;
  localparam logic [COR_W-1:0] COR_AMARELO      = 3'd1;
  localparam logic [COR_W-1:0] COR_VERMELHO     = 3'd2;
  localparam logic [COR_W-1:0] COR_LARANJA      = 3'd3;
  localparam logic [COR_W-1:0] COR_VERDE        = 3'd4;
  localparam logic [COR_W-1:0] COR_AZUL         = 3'd5;
  localparam logic [COR_W-1:0] COR_INVALIDA_MIN = 3'd6;

  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO    = 2'd0;
  localparam estado_t CAPTURA   = 2'd1;
  localparam estado_t VALIDA    = 2'd2;
  localparam estado_t CONCLUIDO = 2'd3;

  // Number of validation steps before the finalising cycle.
`ifdef CENTRO_DISTINTO_EN
  localparam int N_PASSOS = 2 * N_FACES;
`else
  localparam int N_PASSOS = N_FACES;
`endif

  function automatic logic [ADDR_W-1:0] indice(input logic [2:0] face,
                                               input logic [3:0] facelet);
    return ADDR_W'(int'(face) * N_FACELETS + int'(facelet));
  endfunction

endpackage

// File: rtl/monta_estado_cubo_banco_cores.sv
// banco_cores: 54 x 3-bit register file holding the captured cube state.
// Ports:
//   clock, reset (async active-low) ; clr sync clear of all entries
//   we, wr_addr, wr_cor             ; single write port
//   rd_addr -> rd_cor               ; combinational read, 0 beyond entry 53
//   centros (CENTRO_DISTINTO_EN)    ; the six face-centre entries
module banco_cores
  import monta_estado_cubo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COR_W-1:0]  wr_cor,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COR_W-1:0]  rd_cor
`ifdef CENTRO_DISTINTO_EN
  ,
  output logic [N_FACES-1:0][COR_W-1:0] centros
`endif
);

  logic [N_STICKERS-1:0][COR_W-1:0] mem;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < N_STICKERS; i++)
        if (we && wr_addr == ADDR_W'(i)) mem[i] <= wr_cor;
    end
  end

  // Decoded mux keeps out-of-range addresses returning 0.
  always_comb begin
    rd_cor = '0;
    for (int i = 0; i < N_STICKERS; i++)
      if (rd_addr == ADDR_W'(i)) rd_cor = mem[i];
  end

`ifdef CENTRO_DISTINTO_EN
  for (genvar f = 0; f < N_FACES; f++) begin : g_centro
    assign centros[f] = mem[f*N_FACELETS + 4];
  end
`endif

endmodule

// File: rtl/monta_estado_cubo.sv
// monta_estado_cubo: assembles the 54 classified facelet colours of a cube
// capture and validates the per-colour counts.
// Ports:
//   clock, reset (async active-low)
//   iniciar            start/restart pulse, priority over cor_valida
//   cor_valida, cor    facelet colour stream (row-major, faces 0..5)
//   pronto             capture accepting colours
//   face_atual         face being filled
//   fim_face           pulse after each face's 9th facelet
//   cubo_completo      level, validation finished
//   estado_valido      result, meaningful while cubo_completo=1
//   erro_cor           sticky, a code >5 was captured
//   rd_addr -> rd_cor  combinational read of stored state
// Build macro CENTRO_DISTINTO_EN adds a distinct-centre check (6 extra cycles).
module monta_estado_cubo
  import monta_estado_cubo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              cor_valida,
  input  logic [COR_W-1:0]  cor,
  output logic              pronto,
  output logic [2:0]        face_atual,
  output logic              fim_face,
  output logic              cubo_completo,
  output logic              estado_valido,
  output logic              erro_cor,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [COR_W-1:0]  rd_cor
);

  estado_t                        estado;
  logic [3:0]                     facelet;
  logic [N_FACES-1:0][CNT_W-1:0]  contagem;
  logic [3:0]                     passo;
  logic                           flag;
  logic                           escreve;
  logic [CNT_W-1:0]               cnt_sel;

  assign pronto  = (estado == CAPTURA);
  // A colour arriving with iniciar belongs to the aborted capture.
  assign escreve = pronto && cor_valida && !iniciar;

  always_comb begin
    cnt_sel = '0;
    for (int k = 0; k < N_FACES; k++)
      if (passo == 4'(k)) cnt_sel = contagem[k];
  end

`ifdef CENTRO_DISTINTO_EN
  logic [N_FACES-1:0]             vistos;
  logic [N_FACES-1:0][COR_W-1:0]  centros;
  logic [COR_W-1:0]               cen_sel;
  logic                           visto_sel;

  always_comb begin
    cen_sel = '0;
    for (int f = 0; f < N_FACES; f++)
      if (passo == 4'(f + N_FACES)) cen_sel = centros[f];
    visto_sel = 1'b0;
    for (int k = 0; k < N_FACES; k++)
      if (cen_sel == COR_W'(k)) visto_sel = vistos[k];
  end
`endif

  banco_cores u_banco (
    .clock   (clock),
    .reset   (reset),
    .clr     (iniciar),
    .we      (escreve),
    .wr_addr (indice(face_atual, facelet)),
    .wr_cor  (cor),
    .rd_addr (rd_addr),
    .rd_cor  (rd_cor)
`ifdef CENTRO_DISTINTO_EN
    ,
    .centros (centros)
`endif
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado        <= OCIOSO;
      facelet       <= '0;
      face_atual    <= '0;
      contagem      <= '0;
      passo         <= '0;
      flag          <= 1'b0;
      fim_face      <= 1'b0;
      cubo_completo <= 1'b0;
      estado_valido <= 1'b0;
      erro_cor      <= 1'b0;
`ifdef CENTRO_DISTINTO_EN
      vistos        <= '0;
`endif
    end else if (iniciar) begin
      // Same clear from every state: idle start, restart or abort.
      estado        <= CAPTURA;
      facelet       <= '0;
      face_atual    <= '0;
      contagem      <= '0;
      passo         <= '0;
      flag          <= 1'b1;
      fim_face      <= 1'b0;
      cubo_completo <= 1'b0;
      estado_valido <= 1'b0;
      erro_cor      <= 1'b0;
`ifdef CENTRO_DISTINTO_EN
      vistos        <= '0;
`endif
    end else begin
      fim_face <= 1'b0;
      case (estado)
        CAPTURA: begin
          if (cor_valida) begin
            if (cor >= COR_INVALIDA_MIN) begin
              erro_cor <= 1'b1;
            end else begin
              // Saturating so an overfull colour can never alias back to 9.
              for (int k = 0; k < N_FACES; k++)
                if (cor == COR_W'(k) && contagem[k] != {CNT_W{1'b1}})
                  contagem[k] <= contagem[k] + 1'b1;
            end
            if (facelet == 4'd8) begin
              facelet  <= '0;
              fim_face <= 1'b1;
              if (face_atual == 3'd5) begin
                estado <= VALIDA;
                passo  <= '0;
                flag   <= 1'b1;
              end else begin
                face_atual <= face_atual + 3'd1;
              end
            end else begin
              facelet <= facelet + 4'd1;
            end
          end
        end
        VALIDA: begin
          passo <= passo + 4'd1;
          if (passo < 4'd6) begin
            if (cnt_sel != 4'd9) flag <= 1'b0;
          end
`ifdef CENTRO_DISTINTO_EN
          else if (passo < 4'd12) begin
            if (cen_sel >= COR_INVALIDA_MIN || visto_sel) flag <= 1'b0;
            for (int k = 0; k < N_FACES; k++)
              if (cen_sel == COR_W'(k)) vistos[k] <= 1'b1;
          end
`endif
          // One finalising cycle after the last check step.
          if (passo == 4'(N_PASSOS)) begin
            estado        <= CONCLUIDO;
            cubo_completo <= 1'b1;
            estado_valido <= flag && !erro_cor;
          end
        end
        default: ;  // OCIOSO and CONCLUIDO hold; cor_valida ignored
      endcase
    end
  end

endmodule

// File: tb/tb_monta_estado_cubo.sv
module tb_monta_estado_cubo;
  import monta_estado_cubo_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       cor_valida = 1'b0;
  logic [2:0] cor = '0;
  logic       pronto, fim_face, cubo_completo, estado_valido, erro_cor;
  logic [2:0] face_atual;
  logic [5:0] rd_addr = '0;
  logic [2:0] rd_cor;

  monta_estado_cubo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cor_valida(cor_valida),
    .cor(cor), .pronto(pronto), .face_atual(face_atual), .fim_face(fim_face),
    .cubo_completo(cubo_completo), .estado_valido(estado_valido),
    .erro_cor(erro_cor), .rd_addr(rd_addr), .rd_cor(rd_cor)
  );

  always #5 clock = ~clock;

`ifdef CENTRO_DISTINTO_EN
  localparam int LAT = 13;
`else
  localparam int LAT = 7;
`endif

  typedef struct { bit valido; bit erro; int fims; } esp_t;
  esp_t fila[$];
  esp_t e_mon;
  int   checks = 0, errors = 0;
  logic [2:0] stim [54];
  int   cyc = 0, last_wr = 0, fim_cnt = 0;
  bit   prev_cc = 0;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nome, got, exp);
    end
  endtask

  // Reference: count every colour, any code >5 is an error, all six colours
  // must appear exactly nine times (and, with the option, centres distinct).
  function automatic esp_t modelo();
    esp_t m;
    int n[8];
    bit erro = 0, ok = 1;
    for (int c = 0; c < 8; c++) n[c] = 0;
    for (int i = 0; i < 54; i++) begin
      n[stim[i]]++;
      if (stim[i] > 5) erro = 1;
    end
    for (int c = 0; c < 6; c++) if (n[c] != 9) ok = 0;
`ifdef CENTRO_DISTINTO_EN
    for (int f = 0; f < 6; f++)
      for (int g = 0; g < f; g++)
        if (stim[f*9+4] == stim[g*9+4]) ok = 0;
`endif
    m.valido = ok && !erro;
    m.erro   = erro;
    m.fims   = 6;
    return m;
  endfunction

  // Monitor: pops one expectation per rising cubo_completo.
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      fim_cnt <= 0;
      prev_cc <= 0;
    end else begin
      if (iniciar) fim_cnt <= 0;
      else if (fim_face) fim_cnt <= fim_cnt + 1;
      if (pronto && cor_valida && !iniciar) last_wr <= cyc + 1;
      prev_cc <= cubo_completo;
      if (cubo_completo && !prev_cc) begin
        if (fila.size() == 0) begin
          chk("unexpected_completion", 1, 0);
        end else begin
          e_mon = fila.pop_front();
          chk("estado_valido", estado_valido, e_mon.valido);
          chk("erro_cor_end", erro_cor, e_mon.erro);
          chk("fim_face_pulses", fim_cnt, e_mon.fims);
          chk("latency", cyc - last_wr, LAT);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start();
    iniciar = 1; tick(); iniciar = 0;
    chk("start_pronto", pronto, 1);
    chk("start_cubo_completo", cubo_completo, 0);
    chk("start_erro_cor", erro_cor, 0);
    chk("start_face_atual", face_atual, 0);
  endtask

  task automatic feed(input int de, input int ate, input bit gaps);
    bit bad = 0;
    for (int i = de; i < ate; i++) begin
      if (gaps) begin
        int g = $urandom_range(2, 0);
        for (int k = 0; k < g; k++) begin
          cor_valida = 0; cor = 3'($urandom); tick();
        end
      end
      cor_valida = 1; cor = stim[i]; tick();
      cor_valida = 0;
      if (stim[i] > 5) bad = 1;
      chk("erro_cor_running", erro_cor, bad);
    end
  endtask

  task automatic esperar_e_ler();
    int t = 0;
    chk("pronto_after_last", pronto, 0);
    while (!cubo_completo && t < 60) begin @(negedge clock); t++; end
    chk("cubo_completo_seen", cubo_completo, 1);
    // Colours offered after completion must not land anywhere.
    for (int k = 0; k < 3; k++) begin
      cor_valida = 1; cor = 3'($urandom); tick();
    end
    cor_valida = 0;
    chk("cubo_completo_held", cubo_completo, 1);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a); #1;
      chk($sformatf("rd_cor[%0d]", a), rd_cor, (a < 54) ? stim[a] : 3'd0);
    end
    rd_addr = '0;
  endtask

  task automatic solved();
    for (int i = 0; i < 54; i++) stim[i] = 3'(i / 9);
  endtask

  task automatic shuffle();
    for (int i = 53; i > 0; i--) begin
      int j = $urandom_range(i, 0);
      logic [2:0] t = stim[i];
      stim[i] = stim[j]; stim[j] = t;
    end
  endtask

  task automatic run_stream(input bit gaps);
    fila.push_back(modelo());
    start();
    feed(0, 54, gaps);
    esperar_e_ler();
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_pronto", pronto, 0);
    chk("rst_face_atual", face_atual, 0);
    chk("rst_cubo_completo", cubo_completo, 0);
    chk("rst_estado_valido", estado_valido, 0);
    chk("rst_erro_cor", erro_cor, 0);
    chk("rst_fim_face", fim_face, 0);
    reset = 1;
    tick();
    chk("idle_pronto", pronto, 0);

    // Reset in the middle of a capture
    solved();
    start();
    feed(0, 20, 0);
    @(negedge clock); #2 reset = 0; #1;
    chk("midrst_pronto", pronto, 0);
    chk("midrst_face_atual", face_atual, 0);
    chk("midrst_cubo_completo", cubo_completo, 0);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a); #0.1;
      chk($sformatf("midrst_rd[%0d]", a), rd_cor, 0);
    end
    rd_addr = '0;
    tick(); reset = 1; tick();

    // Solved cube, back-to-back
    solved();
    run_stream(0);

    // Entries 0 and 9 swapped: counts unchanged
    solved(); stim[0] = 3'd1; stim[9] = 3'd0;
    run_stream(1);

    // Code 2 ten times, code 5 eight times
    solved(); stim[50] = 3'd2;
    run_stream(0);

    // Invalid code 7 at facelet 12
    solved(); stim[12] = 3'd7;
    run_stream(0);

    // Abort at facelet 30 with a simultaneous (discarded) colour
    solved();
    start();
    feed(0, 30, 0);
    iniciar = 1; cor_valida = 1; cor = 3'd6; tick();
    iniciar = 0; cor_valida = 0;
    chk("abort_face_atual", face_atual, 0);
    chk("abort_erro_cor", erro_cor, 0);
    chk("abort_pronto", pronto, 1);
    rd_addr = 6'd29; #1;
    chk("abort_rd29", rd_cor, 0);
    rd_addr = 6'd0;
    shuffle();
    fila.push_back(modelo());
    feed(0, 54, 1);
    esperar_e_ler();

    // Randomized streams
    for (int r = 0; r < 8; r++) begin
      if (r % 2 == 0) begin
        solved(); shuffle();
      end else begin
        for (int i = 0; i < 54; i++)
          stim[i] = ($urandom_range(19, 0) == 0) ? 3'($urandom_range(7, 6))
                                                 : 3'($urandom_range(5, 0));
      end
      run_stream(r[0]);
    end

    repeat (3) tick();
    chk("queue_drained", fila.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
